// File: rtl/mdu.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and restoring
// divide, one bit per clock, with sign fix-up and a one-cycle done pulse.
module mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return (~v) + 32'd1;
   endfunction

   function automatic logic [63:0] neg64(input logic [63:0] v);
      return (~v) + 64'd1;
   endfunction

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        div_q, div_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] b_q, b_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        signed_s;
   logic [31:0] a_abs_s, b_abs_s;
   logic [32:0] mul_sum_s;
   logic [32:0] div_shift_s, div_diff_s;
   logic [63:0] prod_s;
   logic [31:0] quot_s, rem_s;

   assign signed_s = ~op[0];
   assign a_abs_s  = (signed_s && rs_val[31]) ? neg32(rs_val) : rs_val;
   assign b_abs_s  = (signed_s && rt_val[31]) ? neg32(rt_val) : rt_val;

   // Multiply: acc = {partial product, remaining multiplier bits}
   assign mul_sum_s   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
   // Divide: acc = {partial remainder, dividend bits shifting into quotient}
   assign div_shift_s = {acc_q[63:32], acc_q[31]};
   assign div_diff_s  = div_shift_s - {1'b0, b_q};

   assign prod_s = neg_res_q ? neg64(acc_q) : acc_q;
   assign quot_s = neg_res_q ? neg32(acc_q[31:0]) : acc_q[31:0];
   assign rem_s  = neg_rem_q ? neg32(acc_q[63:32]) : acc_q[63:32];

   // Next-state, datapath and HI/LO update logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      acc_d     = acc_q;
      b_d       = b_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               div_d     = op[1];
               neg_res_d = signed_s & (rs_val[31] ^ rt_val[31]);
               neg_rem_d = signed_s & rs_val[31];
               if (op[1]) begin
                  acc_d = {32'd0, a_abs_s};
                  b_d   = b_abs_s;
               end else begin
                  acc_d = {32'd0, b_abs_s};
                  b_d   = a_abs_s;
               end
               cnt_d   = 6'd0;
               busy_d  = 1'b1;
               state_d = S_ITER;
            end else begin
               if (mthi) begin
                  hi_d = wdata;
               end else begin
                  hi_d = hi_q;
               end
               if (mtlo) begin
                  lo_d = wdata;
               end else begin
                  lo_d = lo_q;
               end
            end
         end
         S_ITER: begin
            if (div_q) begin
               if (!div_diff_s[32]) begin
                  acc_d = {div_diff_s[31:0], acc_q[30:0], 1'b1};
               end else begin
                  acc_d = {div_shift_s[31:0], acc_q[30:0], 1'b0};
               end
            end else begin
               acc_d = {mul_sum_s, acc_q[31:1]};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = S_FIX;
            end else begin
               state_d = S_ITER;
            end
         end
         S_FIX: begin
            if (div_q) begin
               // Divide by zero leaves the dividend in the remainder; only LO needs forcing
               lo_d = (b_q == 32'd0) ? 32'hFFFF_FFFF : quot_s;
               hi_d = rem_s;
            end else begin
               hi_d = prod_s[63:32];
               lo_d = prod_s[31:0];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 6'd0;
         div_q     <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         acc_q     <= 64'd0;
         b_q       <= 32'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         acc_q     <= acc_d;
         b_q       <= b_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the single-cycle CPU datapath, handling MULT/MULTU/DIV/DIVU and owning the architectural HI/LO registers. It sits beside the combinational ALU on the same operand buses. Instead of answering within the cycle, it accepts a start request, computes one bit per clock, and signals completion with a one-cycle done pulse. The control unit stalls the PC while `busy` is high.

## Interface
- WIDTH, 32, operand width; only 32 is supported.

- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request an operation; sampled only in IDLE.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- rs_val  input  32  operand A (multiplicand or dividend).
- rt_val  input  32  operand B (multiplier or divisor).
- mthi  input  1  write wdata to HI; honoured only in IDLE.
- mtlo  input  1  write wdata to LO; honoured only in IDLE.
- wdata  input  32  data for MTHI/MTLO.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when HI/LO have been updated by an operation.
- hi  output  32  HI register: product upper word or remainder.
- lo  output  32  LO register: product lower word or quotient.

## Operation
- **States:** IDLE, ITER, FIX.
  - IDLE→ITER when start=1.
  - ITER→FIX after 32 iterations.
  - FIX→IDLE unconditionally.
- **Capture (IDLE with start):**
  - Latch op.
  - For signed ops (MULT, DIV), latch the absolute values of the operands and record the result signs:
    - product/quotient sign = rs_val[31]^rt_val[31];
    - remainder sign = rs_val[31].
  - For unsigned ops, latch the raw operands.
  - Clear the 6-bit iteration counter and set busy.
- **ITER, multiply:** shift-add. 64-bit accumulator; each cycle examines one multiplier bit, LSB first.
- **ITER, divide:** restoring division. 33-bit partial remainder; one quotient bit per cycle, MSB first.
- **FIX:**
  - Apply two's-complement sign correction for signed ops.
  - Write HI/LO:
    - multiply: {HI,LO} = 64-bit product;
    - divide: LO = quotient, HI = remainder.
  - Assert done for this single cycle; busy deasserts on the same edge.
- **Arithmetic rules:**
  - The signed product is the exact 64-bit two's-complement result.
  - Signed division truncates toward zero.
  - 0x8000_0000 / 0xFFFF_FFFF (signed) gives LO=0x8000_0000, HI=0 (wraps, no trap).
- **Divide by zero (DIV or DIVU):** HI = rs_val as captured, LO = 0xFFFF_FFFF. Normal latency.
- **Boundary and priority rules:**
  - start while busy is ignored; the operation in flight is unaffected.
  - mthi/mtlo while busy are ignored.
  - In IDLE, start and mthi/mtlo in the same cycle: start wins and the writes are dropped.
  - mthi and mtlo together in IDLE write both registers with wdata.
  - hi/lo hold their old values throughout an operation and change only at the FIX edge.
- **Reset:** rst_n low at any time, including mid-operation, forces:
  - state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0;
  - any operation in flight is aborted with no HI/LO update.

## Timing
- Let start be sampled high at edge E0.
  - busy=1 from after E0.
  - Iterations occur at edges E1..E32.
  - FIX occurs at E33: hi/lo are updated, done=1 and busy=0 in the cycle after E33.
  - done returns to 0 after E34.
- Latency from start to valid HI/LO is 33 clocks, identical for all ops and operands, including divide by zero.
- A new start is accepted on the same edge on which done is high (back-to-back, 34-cycle issue interval).
- MTHI/MTLO write on the sampling edge and are visible the next cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF:
  - HI=0xFFFF_FFFE, LO=0x0000_0001;
  - done exactly 33 edges after start; busy high for exactly 33 cycles.
- MULT −3 × 5 (0xFFFF_FFFD, 0x5) → HI=0xFFFF_FFFF, LO=0xFFFF_FFF1.
- DIV −7 / 2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
- DIVU 100 / 7 → LO=14, HI=2.
- Signed overflow and divide by zero:
  - DIV 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0.
  - DIVU 0x1234 / 0 → HI=0x1234, LO=0xFFFF_FFFF.
- Control and reset:
  - start a MULTU; at cycle 10 pulse start with new operands plus mthi → both ignored, original result written.
  - Reassert rst_n low at cycle 20 of a DIVU → hi=lo=0, busy=0, no done.
  - Finally mthi+mtlo with wdata=0xA5A5_A5A5 in IDLE → both registers read 0xA5A5_A5A5.
